// File: rtl/uc_pkg.sv
// ----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the micro-controller front end: default program
// address / instruction widths and the instruction-fetch state encoding.
// ----------------------------------------------------------------------------
package uc_pkg;

    // Program counter / program memory address width.
    localparam int unsigned ADDR_WIDTH  = 12;
    // Instruction word width.
    localparam int unsigned INSTR_WIDTH = 16;
    // Depth of the fetch buffer between memory and decoder.
    localparam int unsigned IF_BUF_DEPTH = 2;

    // Fetch sequencer states.
    //   IDLE : no request outstanding, may issue.
    //   WAIT : one request outstanding, its data will be kept.
    //   DROP : one request outstanding, its data will be discarded (flushed).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage : uc_pkg

// File: rtl/if_buffer.sv
// ----------------------------------------------------------------------------
// if_buffer
// Two-entry FIFO holding fetched {instr, pc} words for the decoder.
// Clear has priority over write and read. A read on an empty buffer is
// ignored. Writing a full buffer (without a same-cycle read) is treated as a
// design error and flagged by an assertion.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   clr_i      in   drop all entries this edge
//   wr_en_i    in   push wr_data_i
//   wr_data_i  in   entry to push
//   rd_en_i    in   pop the head entry
//   rd_data_o  out  head (oldest) entry
//   count_o    out  number of valid entries (0..2)
// ----------------------------------------------------------------------------
module if_buffer #(
    parameter int unsigned DATA_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    logic                  do_rd;
    logic                  do_wr;

    // Effective read/write after emptiness/fullness qualification.
    assign do_rd = rd_en_i && (count_q != 2'd0);
    assign do_wr = wr_en_i && ((count_q != 2'd2) || do_rd);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // The issue logic never lets a reply land in a full buffer.
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (rst)
        !(wr_en_i && !clr_i && (count_q == 2'd2))
    );

endmodule : if_buffer

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. Issues single outstanding reads to program memory
// at the address supplied by the program counter, buffers up to two returned
// words with their addresses, and presents the oldest one to the decoder.
// A flush (program counter redirect) empties the buffer and discards any
// reply still in flight.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   pc_addr      in   current program counter value
//   pc_inc       out  advance program counter by one (same cycle as imem_req)
//   flush        in   redirect, same cycle as the program counter load
//   imem_req     out  program memory read request
//   imem_addr    out  program memory read address
//   imem_rvalid  in   read data valid (1+ cycles after the request)
//   imem_rdata   in   read data
//   if_valid     out  head instruction available
//   if_instr     out  head instruction word
//   if_pc        out  address of the head instruction
//   id_ready     in   decoder accepts the head when if_valid is also 1
//
// imem_req, pc_inc and imem_addr are combinational from the state and the
// current inputs so that the program counter and the memory see the request
// in the cycle it is made. All head outputs read 0 while rst is high.
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned ADDR_WIDTH  = uc_pkg::ADDR_WIDTH,
    parameter int unsigned INSTR_WIDTH = uc_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_inc,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    input  logic                   id_ready
);

    localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;

    uc_pkg::fetch_state_e    state_q;
    logic [ADDR_WIDTH-1:0]   pend_pc_q;

    logic [1:0]              buf_count;
    logic [ENTRY_W-1:0]      buf_head;
    logic [ENTRY_W-1:0]      buf_wdata;
    logic                    buf_wr;
    logic                    buf_rd;
    logic                    buf_nonempty;
    logic                    pending;
    logic [2:0]              occupancy;
    logic                    issue;

    // Buffered entries plus the reply still owed by memory.
    assign pending   = (state_q != uc_pkg::IDLE);
    assign occupancy = 3'(buf_count) + 3'(pending);

    // Request only from IDLE, never during a redirect, and only when the
    // reply is guaranteed a free buffer slot.
    assign issue = !rst && (state_q == uc_pkg::IDLE) && !flush
                   && (occupancy < 3'd2);

    assign imem_req  = issue;
    assign pc_inc    = issue;
    assign imem_addr = issue ? pc_addr : '0;

    // Keep a reply only in WAIT; a flush in the same cycle discards it.
    assign buf_wr    = (state_q == uc_pkg::WAIT) && imem_rvalid && !flush;
    assign buf_wdata = {imem_rdata, pend_pc_q};

    assign buf_nonempty = (buf_count != 2'd0);
    assign buf_rd       = buf_nonempty && id_ready && !flush;

    if_buffer #(
        .DATA_WIDTH (ENTRY_W)
    ) u_if_buffer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .wr_en_i   (buf_wr),
        .wr_data_i (buf_wdata),
        .rd_en_i   (buf_rd),
        .rd_data_o (buf_head),
        .count_o   (buf_count)
    );

    // Decoder-facing view of the head entry, forced to 0 under reset.
    assign if_valid = !rst && buf_nonempty;
    assign if_instr = rst ? '0 : buf_head[ENTRY_W-1 -: INSTR_WIDTH];
    assign if_pc    = rst ? '0 : buf_head[ADDR_WIDTH-1:0];

    // Fetch sequencer and pending-address register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= uc_pkg::IDLE;
            pend_pc_q <= '0;
        end else begin
            unique case (state_q)
                uc_pkg::IDLE: begin
                    if (issue) begin
                        state_q   <= uc_pkg::WAIT;
                        pend_pc_q <= pc_addr;
                    end
                end
                uc_pkg::WAIT: begin
                    // Reply arriving with a flush is simply not written.
                    if (imem_rvalid) begin
                        state_q <= uc_pkg::IDLE;
                    end else if (flush) begin
                        state_q <= uc_pkg::DROP;
                    end
                end
                uc_pkg::DROP: begin
                    // The reply DROP waits for is the one outstanding request,
                    // so it ends DROP even under a further flush; a flush
                    // without the reply keeps DROP.
                    if (imem_rvalid) begin
                        state_q <= uc_pkg::IDLE;
                    end
                end
                default: begin
                    state_q <= uc_pkg::IDLE;
                end
            endcase
        end
    end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with a behavioural program counter and a
// program memory whose latency is programmable (fixed or random 1..4).
// Memory word at address a is 0x1234 + a*0x0101 (16-bit wrap).
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_addr;
    logic          pc_inc;
    logic          flush;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          if_valid;
    logic [IW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          id_ready;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .pc_inc      (pc_inc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Memory / program counter model state
    int            mem_lat  = 1;
    bit            mem_rand = 1'b0;
    bit            mem_busy = 1'b0;
    int            mem_cnt  = 0;
    logic [AW-1:0] mem_addr_q = '0;
    bit            inc_s    = 1'b0;
    int            n_req    = 0;
    int            n_inc    = 0;

    // Random-phase scoreboard
    logic [AW-1:0] exp_pc;
    int            acc;
    int            occ;
    int            max_occ;
    int            cycles;

    function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
        return 16'h1234 + 16'(a) * 16'h0101;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: sample requests at negedge, then at posedge+1 update
    // the memory reply and the program counter; return at posedge+2.
    task automatic cyc();
        @(negedge clk);
        if (imem_req === 1'b1) begin
            mem_busy   = 1'b1;
            mem_addr_q = imem_addr;
            mem_cnt    = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
            n_req++;
        end
        inc_s = (pc_inc === 1'b1);
        if (inc_s) n_inc++;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data(mem_addr_q);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (inc_s) pc_addr = pc_addr + AW'(1);
        #1;
    endtask

    // Hold reset long enough for any in-flight reply to drain; returns with
    // rst released at the start of cycle 1.
    task automatic do_reset(input logic [AW-1:0] addr);
        rst      = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        mem_rand = 1'b0;
        mem_lat  = 1;
        pc_addr  = addr;
        #2;
        chk("rst_if_valid",  32'(if_valid),  32'h0);
        chk("rst_if_instr",  32'(if_instr),  32'h0);
        chk("rst_if_pc",     32'(if_pc),     32'h0);
        chk("rst_imem_req",  32'(imem_req),  32'h0);
        chk("rst_pc_inc",    32'(pc_inc),    32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        repeat (5) cyc();
        rst     = 1'b0;
        pc_addr = addr;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        id_ready    = 1'b0;
        pc_addr     = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // ---- basic fetch, 1-cycle memory, decoder ready ----
        do_reset(12'h000);
        id_ready = 1'b1;
        #2;
        chk("t1_c1_req",   32'(imem_req),  32'h1);
        chk("t1_c1_inc",   32'(pc_inc),    32'h1);
        chk("t1_c1_addr",  32'(imem_addr), 32'h000);
        chk("t1_c1_valid", 32'(if_valid),  32'h0);
        cyc();
        #2;
        chk("t1_c2_req",   32'(imem_req),  32'h0);
        chk("t1_c2_inc",   32'(pc_inc),    32'h0);
        chk("t1_c2_valid", 32'(if_valid),  32'h0);
        cyc();
        #2;
        chk("t1_c3_valid", 32'(if_valid),  32'h1);
        chk("t1_c3_instr", 32'(if_instr),  32'h1234);
        chk("t1_c3_pc",    32'(if_pc),     32'h000);
        cyc();

        // ---- decoder stalled: buffer fills, then drains in order ----
        do_reset(12'h010);
        #2;
        chk("t2_c1_req",  32'(imem_req),  32'h1);
        chk("t2_c1_addr", 32'(imem_addr), 32'h010);
        cyc();
        #2;
        cyc();
        #2;
        chk("t2_c3_req",  32'(imem_req),  32'h1);
        chk("t2_c3_addr", 32'(imem_addr), 32'h011);
        chk("t2_c3_pc",   32'(if_pc),     32'h010);
        cyc();
        #2;
        cyc();
        #2;
        chk("t2_c5_req",   32'(imem_req), 32'h0);
        chk("t2_c5_valid", 32'(if_valid), 32'h1);
        chk("t2_c5_pc",    32'(if_pc),    32'h010);
        chk("t2_c5_instr", 32'(if_instr), 32'h2244);
        cyc();
        #2;
        chk("t2_c6_req",   32'(imem_req), 32'h0);
        chk("t2_c6_pc",    32'(if_pc),    32'h010);
        chk("t2_c6_instr", 32'(if_instr), 32'h2244);
        cyc();
        id_ready = 1'b1;
        #2;
        chk("t2_c7_pc",    32'(if_pc),    32'h010);
        chk("t2_c7_instr", 32'(if_instr), 32'h2244);
        chk("t2_c7_req",   32'(imem_req), 32'h0);
        cyc();
        #2;
        chk("t2_c8_valid", 32'(if_valid), 32'h1);
        chk("t2_c8_pc",    32'(if_pc),    32'h011);
        chk("t2_c8_instr", 32'(if_instr), 32'h2345);
        cyc();

        // ---- flush while waiting on a 3-cycle memory: DROP ----
        do_reset(12'h100);
        id_ready = 1'b1;
        mem_lat  = 3;
        #2;
        chk("t3_c1_req",  32'(imem_req),  32'h1);
        chk("t3_c1_addr", 32'(imem_addr), 32'h100);
        cyc();
        flush   = 1'b1;
        pc_addr = 12'h200;
        #2;
        chk("t3_c2_req", 32'(imem_req), 32'h0);
        cyc();
        flush = 1'b0;
        #2;
        chk("t3_c3_req",   32'(imem_req), 32'h0);
        chk("t3_c3_valid", 32'(if_valid), 32'h0);
        cyc();
        mem_lat = 1;
        #2;
        chk("t3_c4_rvalid", 32'(imem_rvalid), 32'h1);
        chk("t3_c4_req",    32'(imem_req),    32'h0);
        chk("t3_c4_valid",  32'(if_valid),    32'h0);
        cyc();
        #2;
        chk("t3_c5_req",   32'(imem_req),  32'h1);
        chk("t3_c5_addr",  32'(imem_addr), 32'h200);
        chk("t3_c5_valid", 32'(if_valid),  32'h0);
        cyc();
        #2;
        chk("t3_c6_valid", 32'(if_valid), 32'h0);
        cyc();
        #2;
        chk("t3_c7_valid", 32'(if_valid), 32'h1);
        chk("t3_c7_pc",    32'(if_pc),    32'h200);
        chk("t3_c7_instr", 32'(if_instr), 32'h1434);
        cyc();

        // ---- flush together with reply and accept, one entry buffered ----
        do_reset(12'h300);
        #2;
        chk("t4_c1_req", 32'(imem_req), 32'h1);
        cyc();
        #2;
        cyc();
        #2;
        chk("t4_c3_valid", 32'(if_valid),  32'h1);
        chk("t4_c3_pc",    32'(if_pc),     32'h300);
        chk("t4_c3_addr",  32'(imem_addr), 32'h301);
        cyc();
        id_ready = 1'b1;
        flush    = 1'b1;
        pc_addr  = 12'h380;
        #2;
        chk("t4_c4_rvalid", 32'(imem_rvalid), 32'h1);
        chk("t4_c4_req",    32'(imem_req),    32'h0);
        cyc();
        flush = 1'b0;
        #2;
        chk("t4_c5_valid", 32'(if_valid),  32'h0);
        chk("t4_c5_req",   32'(imem_req),  32'h1);
        chk("t4_c5_addr",  32'(imem_addr), 32'h380);
        cyc();
        #2;
        cyc();
        #2;
        chk("t4_c7_valid", 32'(if_valid), 32'h1);
        chk("t4_c7_pc",    32'(if_pc),    32'h380);
        chk("t4_c7_instr", 32'(if_instr), 32'h95b4);
        cyc();

        // ---- reset mid-request, stale reply after release ----
        do_reset(12'h400);
        id_ready = 1'b1;
        mem_lat  = 2;
        #2;
        chk("t5_c1_req",  32'(imem_req),  32'h1);
        chk("t5_c1_addr", 32'(imem_addr), 32'h400);
        cyc();
        rst = 1'b1;
        #2;
        chk("t5_c2_req",   32'(imem_req), 32'h0);
        chk("t5_c2_valid", 32'(if_valid), 32'h0);
        cyc();
        rst     = 1'b0;
        pc_addr = 12'h450;
        #2;
        chk("t5_c3_rvalid", 32'(imem_rvalid), 32'h1);
        chk("t5_c3_req",    32'(imem_req),    32'h1);
        chk("t5_c3_addr",   32'(imem_addr),   32'h450);
        chk("t5_c3_valid",  32'(if_valid),    32'h0);
        cyc();
        #2;
        chk("t5_c4_valid", 32'(if_valid), 32'h0);
        cyc();
        #2;
        chk("t5_c5_valid", 32'(if_valid), 32'h0);
        cyc();
        #2;
        chk("t5_c6_valid", 32'(if_valid), 32'h1);
        chk("t5_c6_pc",    32'(if_pc),    32'h450);
        chk("t5_c6_instr", 32'(if_instr), 32'h6684);
        cyc();

        // ---- random decoder stalls and memory latency 1..4 ----
        do_reset(12'h000);
        mem_rand = 1'b1;
        n_req    = 0;
        n_inc    = 0;
        exp_pc   = '0;
        acc      = 0;
        max_occ  = 0;
        cycles   = 0;
        while (acc < 1000 && cycles < 20000) begin
            id_ready = 1'($urandom_range(0, 1));
            #2;
            occ = n_req + int'(imem_req) - acc;
            if (occ > max_occ) max_occ = occ;
            if (if_valid && id_ready) begin
                chk("rnd_pc",    32'(if_pc),    32'(exp_pc));
                chk("rnd_instr", 32'(if_instr), 32'(mem_data(exp_pc)));
                exp_pc = exp_pc + AW'(1);
                acc++;
            end
            cyc();
            cycles++;
        end
        chk("rnd_accepts",    32'(acc),            32'd1000);
        chk("rnd_max_occ_le2", 32'(max_occ <= 2),  32'h1);
        chk("rnd_inc_eq_req", 32'(n_inc),          32'(n_req));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning program address width, equal to the program counter width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16, meaning instruction word width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 pc_addr  input  ADDR_WIDTH  current address from the program counter.
REQ-007 pc_inc  output  1  one-cycle pulse telling the program counter to advance by 1.
REQ-008 flush  input  1  redirect, asserted in the same cycle as the program counter load.
REQ-009 imem_req  output  1  program memory read request.
REQ-010 imem_addr  output  ADDR_WIDTH  read address.
REQ-011 imem_rvalid  input  1  read data valid, arriving 1 or more cycles after imem_req.
REQ-012 imem_rdata  input  INSTR_WIDTH  read data.
REQ-013 if_valid  output  1  instruction available to the decoder.
REQ-014 if_instr  output  INSTR_WIDTH  head instruction.
REQ-015 if_pc  output  ADDR_WIDTH  address of the head instruction.
REQ-016 id_ready  input  1  decoder accepts the head; transfer occurs when if_valid and id_ready are both 1.

Function
REQ-017 SHALL allow at most one outstanding memory request.
REQ-018 SHALL hold a 2-entry instruction buffer of {instr, pc}; if_valid = buffer not empty; if_instr and if_pc show the oldest entry.
REQ-019 SHALL use states IDLE, WAIT and DROP.
REQ-020 IDLE: SHALL assert imem_req and pc_inc, and drive imem_addr = pc_addr, when flush=0 and (entries + pending) < 2; then go to WAIT.
REQ-021 imem_req and pc_inc SHALL be combinational, in the same cycle, and asserted only in IDLE.
REQ-022 SHALL latch pc_addr as the pending pc on issue.
REQ-023 WAIT: on imem_rvalid=1 with flush=0, SHALL write {imem_rdata, pending pc} to the buffer and go to IDLE.
REQ-024 A new request SHALL NOT be issued in the cycle the data returns.
REQ-025 Back-to-back throughput SHALL therefore be at most one instruction every 2 cycles with 1-cycle memory latency.
REQ-026 flush SHALL empty the buffer in the same edge.
REQ-027 On flush in WAIT with imem_rvalid=0: SHALL go to DROP.
REQ-028 On flush in WAIT with imem_rvalid=1: SHALL discard the data and go to IDLE.
REQ-029 On flush in IDLE: SHALL NOT issue a request that cycle.
REQ-030 DROP: SHALL discard the data on imem_rvalid=1, go to IDLE, and issue nothing while in DROP.
REQ-031 flush in DROP SHALL keep state DROP.
REQ-032 flush SHALL take priority over a simultaneous decoder accept and a simultaneous buffer write.
REQ-033 A simultaneous buffer write and accept with a non-empty buffer SHALL keep the count unchanged and preserve order.
REQ-034 imem_rvalid outside WAIT and DROP SHALL be ignored.
REQ-035 A write to a full buffer is unreachable by REQ-020 and SHALL be flagged by an assertion.
REQ-036 if_instr and if_pc SHALL be stable while if_valid=1 and id_ready=0.

Reset
REQ-037 On rst=1 at a clock edge: state IDLE, buffer empty, pending pc cleared to 0.
REQ-038 While rst=1: if_valid=0, if_instr=0, if_pc=0, imem_req=0, pc_inc=0, imem_addr=0.
REQ-039 Reset asserted mid-request SHALL abandon the request; a late imem_rvalid after reset SHALL be ignored because the state is IDLE.

Structure
REQ-040 Shared package uc_pkg SHALL hold ADDR_WIDTH, INSTR_WIDTH and the fetch state enum (IDLE, WAIT, DROP).
REQ-041 The buffer SHALL be sub-module if_buffer: 2-entry FIFO with clear, write, read, count, and width parameter ADDR_WIDTH+INSTR_WIDTH.
REQ-042 The state machine and issue logic SHALL live in instr_fetch.

Verification
REQ-043 Reset then pc_addr=0x000, 1-cycle memory returning 0x1234, id_ready=1 -> imem_req and pc_inc pulse on cycle 1; if_valid=1, if_instr=0x1234, if_pc=0x000 on cycle 3.
REQ-044 id_ready=0, addresses 0x010 and 0x011 -> two fetches, then imem_req stays 0; after id_ready=1, outputs 0x010 then 0x011 in order.
REQ-045 flush while WAIT with 3-cycle memory latency -> DROP entered; returned word not visible; next request uses the new pc_addr=0x200; if_pc=0x200.
REQ-046 flush in the same cycle as imem_rvalid and id_ready=1 with 1 entry -> buffer empty next cycle; no accept counted; state IDLE.
REQ-047 rst asserted in WAIT, imem_rvalid one cycle after rst is released -> if_valid stays 0; fresh request issued from pc_addr.
REQ-048 Random id_ready and memory latency 1-4 for 1000 instructions -> if_pc sequence strictly +1, never more than 2 entries, pc_inc count equals imem_req count.
